fetch_unit: RTL and testbench

Decoupled instruction-fetch front end for the five-stage pipeline. It owns the program counter, issues in-order fetch requests to a variable-latency instruction memory, buffers returned instructions in a small FIFO, and presents them to the IF/ID pipeline register. The hazard/AI stall holds delivery, and branch/jump redirects flush all in-flight work.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit_chk.sv | 18 +
 rtl/fetch_unit_sync_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 6 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  // One buffered fetch result: the PC it was fetched from and the word returned.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: instruction-memory handshake, IF/ID delivery and control inputs.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic               stall;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               imem_req_valid;
  logic [31:0]        imem_req_addr;
  logic               imem_req_ready;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               if_valid;
  logic [31:0]        if_pc;
  logic [INSTR_W-1:0] if_instruction;

  // Fetch unit side.
  modport master (
    input  stall, redirect_valid, redirect_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output imem_req_valid, imem_req_addr,
    output if_valid, if_pc, if_instruction
  );

  // Memory / pipeline side.
  modport slave (
    output stall, redirect_valid, redirect_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  imem_req_valid, imem_req_addr,
    input  if_valid, if_pc, if_instruction
  );
endinterface

// File: rtl/fetch_unit_chk.sv
// Simulation checks on the fetch unit's memory protocol and drop bookkeeping.
module fetch_unit_chk #(
  parameter int CW = 4
) (
  input logic          clk,
  input logic          reset,
  input logic          resp_valid,
  input logic [CW-1:0] inflight,
  input logic [CW-1:0] drop
);
  // A response must always correspond to an outstanding request.
  a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
    resp_valid |-> (inflight != {CW{1'b0}}));

  // Stale responses can never exceed what is still in flight.
  a_drop_bounded: assert property (@(posedge clk) disable iff (reset)
    drop <= inflight);
endmodule

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_C    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C     = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE_C = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify push/pop against current occupancy so overflow/underflow cannot corrupt state.
  always_comb begin
    push_ok_s = push && (count_r != FULL_C);
    pop_ok_s  = pop && (count_r != {(AW+1){1'b0}});
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage write; entries are only ever read while counted valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush && !reset) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign count    = count_r;
endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch front end: PC, credit-limited requests, response buffer, redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   resp_pc_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] drop_r;

  logic [AW:0]   fifo_count_s;
  logic [CW-1:0] count_ext_s;
  logic [CW-1:0] credit_s;
  logic          req_valid_s;
  logic          accept_s;
  logic          resp_s;
  logic          keep_s;
  logic          head_valid_s;
  logic          pop_s;
  logic [31:0]   redirect_target_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  head_entry_s;

  // Request credit, response classification and dequeue decisions.
  always_comb begin
    count_ext_s       = {1'b0, fifo_count_s};
    credit_s          = count_ext_s + inflight_r - drop_r;
    req_valid_s       = !reset && !bus.redirect_valid && (credit_s < DEPTH_C);
    accept_s          = req_valid_s && bus.imem_req_ready;
    // A response with nothing outstanding is illegal and ignored.
    resp_s            = bus.imem_resp_valid && (inflight_r != ZERO_C);
    keep_s            = resp_s && (drop_r == ZERO_C) && !bus.redirect_valid;
    head_valid_s      = (fifo_count_s != {(AW+1){1'b0}});
    pop_s             = head_valid_s && !bus.stall && !bus.redirect_valid;
    redirect_target_s = align_pc(bus.redirect_pc);
    push_entry_s.pc    = resp_pc_r;
    push_entry_s.instr = bus.imem_resp_data;
  end

  // PC and outstanding-request bookkeeping; redirect turns everything in flight stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      inflight_r <= ZERO_C;
      drop_r     <= ZERO_C;
    end else if (bus.redirect_valid) begin
      fetch_pc_r <= redirect_target_s;
      resp_pc_r  <= redirect_target_s;
      inflight_r <= inflight_r - {{(CW-1){1'b0}}, resp_s};
      drop_r     <= inflight_r - {{(CW-1){1'b0}}, resp_s};
    end else begin
      if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + PC_INC;
      end
      if (keep_s) begin
        resp_pc_r <= resp_pc_r + PC_INC;
      end
      inflight_r <= inflight_r + {{(CW-1){1'b0}}, accept_s} - {{(CW-1){1'b0}}, resp_s};
      if (resp_s && (drop_r != ZERO_C)) begin
        drop_r <= drop_r - ONE_C;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (keep_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .pop_data  (head_entry_s),
    .count     (fifo_count_s)
  );

  // Output drive; head fields read as zero while the buffer is empty.
  always_comb begin
    bus.imem_req_valid = req_valid_s;
    bus.imem_req_addr  = fetch_pc_r;
    bus.if_valid       = head_valid_s;
    if (head_valid_s) begin
      bus.if_pc          = head_entry_s.pc;
      bus.if_instruction = head_entry_s.instr;
    end else begin
      bus.if_pc          = 32'h0000_0000;
      bus.if_instruction = 32'h0000_0000;
    end
  end

  fetch_unit_chk #(.CW(CW)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .resp_valid (bus.imem_resp_valid),
    .inflight   (inflight_r),
    .drop       (drop_r)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a queue-based reference of the fetch rules.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic clk;
  logic reset;
  fetch_unit_if bus();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  int delivered = 0;

  mreq_t        mem_q[$];
  fetch_entry_t m_fifo[$];
  logic [31:0]  m_fetch = RESET_PC;
  logic [31:0]  m_resp = RESET_PC;
  logic [31:0]  exp_next = RESET_PC;
  int           m_drop = 0;

  logic        s_if_valid;
  logic [31:0] s_if_pc;
  logic        s_req_valid;
  logic [31:0] s_req_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check against the reference, then advance both.
  task automatic tick(input logic rst, input logic stl, input logic redir,
                      input logic [31:0] tgt, input logic rdy);
    logic         resp;
    logic [31:0]  raddr;
    logic         exp_req;
    logic         accept;
    int           credit;
    mreq_t        mr;
    fetch_entry_t e;
    resp  = !rst && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    raddr = resp ? mem_q[0].addr : 32'h0;
    reset = rst;
    bus.stall = stl;
    bus.redirect_valid = redir;
    bus.redirect_pc = tgt;
    bus.imem_req_ready = rdy;
    bus.imem_resp_valid = resp;
    bus.imem_resp_data = resp ? (raddr | 32'hA000_0000) : 32'h0;
    #1;
    s_if_valid  = bus.if_valid;
    s_if_pc     = bus.if_pc;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    exp_req = 1'b0;
    if (rst) begin
      chk("req_in_reset", {31'd0, s_req_valid}, 32'd0);
    end else begin
      credit  = m_fifo.size() + mem_q.size() - m_drop;
      exp_req = !redir && (credit < DEPTH);
      chk("req_valid", {31'd0, s_req_valid}, {31'd0, exp_req});
      chk("req_addr", s_req_addr, m_fetch);
      chk("if_valid", {31'd0, s_if_valid}, {31'd0, m_fifo.size() != 0});
      if (m_fifo.size() != 0) begin
        chk("if_pc", s_if_pc, m_fifo[0].pc);
        chk("if_instr", bus.if_instruction, m_fifo[0].instr);
      end
    end
    accept = !rst && bus.imem_req_valid && rdy;
    if (resp) void'(mem_q.pop_front());
    if (rst) begin
      m_fifo.delete();
      mem_q.delete();
      m_drop = 0;
      m_fetch = RESET_PC;
      m_resp = RESET_PC;
      exp_next = RESET_PC;
    end else if (redir) begin
      m_fifo.delete();
      m_fetch = tgt & 32'hFFFF_FFFC;
      m_resp = tgt & 32'hFFFF_FFFC;
      exp_next = tgt & 32'hFFFF_FFFC;
      m_drop = mem_q.size();
    end else begin
      if (m_fifo.size() != 0 && !stl) begin
        chk("seq_pc", s_if_pc, exp_next);
        exp_next = exp_next + 32'd4;
        delivered++;
        void'(m_fifo.pop_front());
      end
      if (resp) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          e.pc = m_resp;
          e.instr = m_resp | 32'hA000_0000;
          m_fifo.push_back(e);
          m_resp = m_resp + 32'd4;
        end
      end
      if (exp_req && rdy) m_fetch = m_fetch + 32'd4;
    end
    if (accept) begin
      mr.addr = bus.imem_req_addr;
      mr.due = cyc + $urandom_range(lat_max, lat_min);
      mem_q.push_back(mr);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held;
    logic        hit;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = 32'h0;
    @(negedge clk);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Streaming after reset, L = 1, always ready.
    for (int t = 0; t < 20; t++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if (t == 0) begin
        chk("rst_if_valid", {31'd0, s_if_valid}, 32'd0);
        chk("rst_req_addr", s_req_addr, RESET_PC);
      end
      if (t == 1) chk("cyc1_if_valid", {31'd0, s_if_valid}, 32'd0);
      if (t == 2) begin
        chk("cyc2_if_valid", {31'd0, s_if_valid}, 32'd1);
        chk("cyc2_if_pc", s_if_pc, 32'h0);
      end
    end

    // Stall for 10 cycles: head frozen, requests stop once credits run out.
    held = 32'h0;
    for (int t = 0; t < 10; t++) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      if (t == 0) held = s_if_pc;
    end
    chk("stall_hold_pc", s_if_pc, held);
    chk("stall_req_off", {31'd0, s_req_valid}, 32'd0);
    for (int t = 0; t < 12; t++) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // L = 3, redirect to 0x103 with exactly two requests outstanding.
    lat_min = 3;
    lat_max = 3;
    for (int t = 0; t < 8; t++) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
    chk("redir_next_valid", {31'd0, s_if_valid}, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_r1_if_valid", {31'd0, s_if_valid}, 32'd0);
    chk("redir_r1_req", {31'd0, s_req_valid}, 32'd1);
    for (int t = 0; t < 20 && !s_if_valid; t++) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_first_valid", {31'd0, s_if_valid}, 32'd1);
    chk("redir_first_pc", s_if_pc, 32'h0000_0100);
    tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int t = 0; t < 20 && !s_if_valid; t++) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_second_pc", s_if_pc, 32'h0000_0104);

    // Redirect in the same cycle as a response and a dequeue.
    lat_min = 1;
    lat_max = 2;
    hit = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (!hit && mem_q.size() != 0 && mem_q[0].due <= cyc && m_fifo.size() != 0) begin
        hit = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1);
      end else begin
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      end
    end
    chk("coincident_redirect_seen", {31'd0, hit}, 32'd1);

    // Random ready, latency 1..4, stalls and occasional redirects.
    lat_min = 1;
    lat_max = 4;
    delivered = 0;
    for (int t = 0; t < 20000 && delivered < 1000; t++) begin
      tick(1'b0, ($urandom_range(4, 0) == 0), ($urandom_range(99, 0) == 0),
           $urandom_range(32'h0000_FFFF, 0), $urandom_range(1, 0) == 1);
    end
    chk("delivered_1000", {31'd0, delivered >= 1000}, 32'd1);

    // Reset while the buffer holds three entries.
    lat_min = 1;
    lat_max = 1;
    for (int t = 0; t < 30 && m_fifo.size() != 3; t++) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("pre_reset_three", {31'd0, s_if_valid}, 32'd1);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("post_reset_if_valid", {31'd0, s_if_valid}, 32'd0);
    chk("post_reset_addr", s_req_addr, RESET_PC);
    for (int t = 0; t < 10; t++) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
